scan_index_gen: RTL and testbench
=================================

// Module: scan_index_gen
// PURPOSE
//  Timed 2-bit select generator that drives the i1/i0 inputs of the 2-to-4 line decoder.
//  It steps a digit/row index 0..3 at a programmable rate, for multiplexed display or
//  keypad scanning. The decoder's one-hot outputs become the scan strobes.
//  It also provides a blank strobe for gating the decoder outputs, plus tick and wrap
//  events for downstream data muxing.
// PARAMETERS
//  DIV_W      16    width of the prescaler counter
//  DIV        1000  clocks per index step; legal range 1..2**DIV_W-1
//  BLANK_CYC  2     dead cycles inserted per step; used only when SCAN_BLANK_EN is defined; legal range >=1
// PORTS
//  clk       input   1  rising-edge clock
//  rst_n     input   1  asynchronous active-low reset
//  en        input   1  run enable; 0 = stop and blank
//  dir       input   1  0 = count up (0,1,2,3,0..), 1 = count down (3,2,1,0,3..)
//  load      input   1  synchronous index load strobe
//  load_val  input   2  value loaded into the index when load=1
//  i1        output  1  index bit 1 (MSB), connects to decoder i1
//  i0        output  1  index bit 0 (LSB), connects to decoder i0
//  tick      output  1  one-cycle pulse in the cycle the index changes due to stepping
//  wrap      output  1  one-cycle pulse coincident with tick when the index crosses 3->0 (up) or 0->3 (down)
//  blank     output  1  1 = downstream shall suppress decoder outputs
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous)
//   - prescaler=0, idx=0, i1=i0=0, tick=0, wrap=0, blank=1, state=IDLE.
//  Outputs and state
//   - All outputs are registered; {i1,i0}=idx.
//   - Three states: IDLE, RUN, BLANK. BLANK exists only when SCAN_BLANK_EN is defined.
//  IDLE
//   - blank=1 and the prescaler is held at 0.
//   - en=1 -> RUN at the next edge; blank=0 from that edge.
//  RUN
//   - The prescaler increments each cycle.
//   - At prescaler==DIV-1, on the next edge:
//     - prescaler<=0;
//     - idx<=idx+1 when dir=0, or idx-1 when dir=1 (mod 4, natural 2-bit wrap);
//     - tick<=1, and wrap<=1 when wrapping.
//   - With DIV=1, the index steps every cycle and tick stays high continuously.
//  en=0 in any state
//   - The next edge goes to IDLE, sets blank=1 and clears the prescaler.
//   - idx holds its value.
//   - A step scheduled for that same edge is discarded: no tick.
//  load=1
//   - Priority: reset > load > en/step.
//   - At the next edge: idx<=load_val, prescaler<=0, tick=wrap=0.
//   - The state is unchanged, except that BLANK returns to RUN.
//  dir
//   - Sampled only on the step edge.
//   - A change between steps affects only the next step; no glitch.
//  tick and wrap
//   - Both last exactly one cycle, except in the DIV=1 continuous case.
//   - wrap is never asserted without tick.
// CONFIGURATION
//  SCAN_BLANK_EN defined
//   - The step edge moves RUN->BLANK and sets blank<=1 on the same edge that idx changes,
//     so the decoder switches while its outputs are gated (anti-ghosting).
//   - BLANK lasts BLANK_CYC cycles, with the prescaler held at 0.
//   - Then BLANK->RUN and blank<=0.
//   - Step period = DIV+BLANK_CYC cycles.
//  SCAN_BLANK_EN undefined
//   - The BLANK state and its counter are not built.
//   - BLANK_CYC is ignored.
//   - blank = (state==IDLE).
//   - Step period = DIV cycles.
// TESTING
//  T1 reset: rst_n=0 mid-RUN with idx=2 -> immediately idx=0, blank=1, tick=wrap=0; en held 1 after release -> blank=0 one edge later.
//  T2 up scan, DIV=4, no macro: en=1, dir=0 -> idx 0,1,2,3,0 changes every 4 cycles; tick pulses once per change; wrap only on 3->0.
//  T3 down + dir flip: dir=1 from idx=0 -> next step gives idx=3 with wrap=1; dir=0 set mid-period -> next step gives idx=0 with wrap=1.
//  T4 load collision: load=1, load_val=2 on the cycle the prescaler hits DIV-1 -> idx=2, tick=0, prescaler=0; next step after 4 more cycles gives idx=3.
//  T5 stop/start: en=0 for 3 cycles at idx=1 -> blank=1, idx stays 1, no tick; en=1 -> first step occurs DIV cycles after RUN entry.
//  T6 SCAN_BLANK_EN, DIV=4, BLANK_CYC=2: blank=1 on each idx-change edge and held 2 cycles; steps every 6 cycles; i1/i0 never change while blank=0.

Source files
------------

// File: rtl/scan_index_gen.sv
// scan_index_gen: timed 2-bit scan index for a 2-to-4 line decoder.
// The index steps 0..3 (up or down) once every DIV clocks while enabled, and
// emits tick/wrap pulses for the downstream data mux. blank tells the consumer
// to gate the decoder outputs.
// Optional build macro SCAN_BLANK_EN: inserts BLANK_CYC dead cycles after every
// index change, so the decoder switches only while its outputs are gated.
module scan_index_gen #(
    parameter int DIV_W     = 16,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic       i1,
    output logic       i0,
    output logic       tick,
    output logic       wrap,
    output logic       blank
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [DIV_W-1:0] PRE_LAST = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0] PRE_ONE  = DIV_W'(1);

`ifdef SCAN_BLANK_EN
    localparam logic [1:0] ST_BLANK = 2'd2;
    localparam int BCW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [BCW-1:0] BCNT_LAST = BCW'(BLANK_CYC - 1);
    localparam logic [BCW-1:0] BCNT_ONE  = BCW'(1);

    logic [BCW-1:0] blank_cnt_r;
    logic [BCW-1:0] blank_cnt_s;
`else
    // The dead-cycle count has no meaning when the blank phase is not built.
    localparam int BLANK_CYC_UNUSED = BLANK_CYC;
`endif

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [DIV_W-1:0] pre_r;
    logic [DIV_W-1:0] pre_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_s;
    logic             tick_r;
    logic             tick_s;
    logic             wrap_r;
    logic             wrap_s;
    logic             blank_r;
    logic             blank_s;

    // Next index value for one step in the requested direction (natural 2-bit wrap).
    function automatic logic [1:0] step_idx(input logic [1:0] cur, input logic down);
        logic [1:0] nxt;
        if (down) begin
            nxt = cur - 2'd1;
        end else begin
            nxt = cur + 2'd1;
        end
        return nxt;
    endfunction

    // True when a step from cur in the given direction crosses the 3/0 boundary.
    function automatic logic step_wraps(input logic [1:0] cur, input logic down);
        logic w;
        if (down) begin
            w = (cur == 2'd0);
        end else begin
            w = (cur == 2'd3);
        end
        return w;
    endfunction

    // Next-state logic: load beats enable, disable beats a pending step.
    always_comb begin
        state_s = state_r;
        pre_s   = pre_r;
        idx_s   = idx_r;
        tick_s  = 1'b0;
        wrap_s  = 1'b0;
        blank_s = blank_r;
`ifdef SCAN_BLANK_EN
        blank_cnt_s = blank_cnt_r;
`endif
        if (load) begin
            idx_s = load_val;
            pre_s = '0;
            if (state_r == ST_IDLE) begin
                state_s = ST_IDLE;
                blank_s = 1'b1;
            end else begin
                // A load during the dead phase resumes scanning straight away.
                state_s = ST_RUN;
                blank_s = 1'b0;
`ifdef SCAN_BLANK_EN
                blank_cnt_s = '0;
`endif
            end
        end else if (!en) begin
            state_s = ST_IDLE;
            blank_s = 1'b1;
            pre_s   = '0;
`ifdef SCAN_BLANK_EN
            blank_cnt_s = '0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_RUN;
                    blank_s = 1'b0;
                    pre_s   = '0;
                end
                ST_RUN: begin
                    if (pre_r == PRE_LAST) begin
                        pre_s  = '0;
                        idx_s  = step_idx(idx_r, dir);
                        tick_s = 1'b1;
                        wrap_s = step_wraps(idx_r, dir);
`ifdef SCAN_BLANK_EN
                        state_s     = ST_BLANK;
                        blank_s     = 1'b1;
                        blank_cnt_s = '0;
`else
                        state_s = ST_RUN;
                        blank_s = 1'b0;
`endif
                    end else begin
                        pre_s = pre_r + PRE_ONE;
                    end
                end
`ifdef SCAN_BLANK_EN
                ST_BLANK: begin
                    pre_s = '0;
                    if (blank_cnt_r == BCNT_LAST) begin
                        state_s     = ST_RUN;
                        blank_s     = 1'b0;
                        blank_cnt_s = '0;
                    end else begin
                        blank_s     = 1'b1;
                        blank_cnt_s = blank_cnt_r + BCNT_ONE;
                    end
                end
`endif
                default: begin
                    state_s = ST_IDLE;
                    blank_s = 1'b1;
                    pre_s   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset parks the scanner idle and blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pre_r   <= '0;
            idx_r   <= 2'd0;
            tick_r  <= 1'b0;
            wrap_r  <= 1'b0;
            blank_r <= 1'b1;
        end else begin
            state_r <= state_s;
            pre_r   <= pre_s;
            idx_r   <= idx_s;
            tick_r  <= tick_s;
            wrap_r  <= wrap_s;
            blank_r <= blank_s;
        end
    end

`ifdef SCAN_BLANK_EN
    // Dead-cycle counter for the gated phase after each step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_cnt_r <= '0;
        end else begin
            blank_cnt_r <= blank_cnt_s;
        end
    end
`endif

    assign i1    = idx_r[1];
    assign i0    = idx_r[0];
    assign tick  = tick_r;
    assign wrap  = wrap_r;
    assign blank = blank_r;

endmodule

// File: tb/tb_scan_index_gen.sv
// Directed bench for scan_index_gen with DIV=4 (plus a DIV=1 instance for the
// continuous-tick case). Build with SCAN_BLANK_EN to exercise the blank phase.
module tb_scan_index_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic       load;
    logic [1:0] load_val;
    logic       i1, i0, tick, wrap, blank;

    logic       en1;
    logic       d1_i1, d1_i0, d1_tick, d1_wrap, d1_blank;

    int pass_cnt;
    int chk_cnt;
    int exp_idx;

    scan_index_gen #(.DIV_W(16), .DIV(4), .BLANK_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .i1(i1), .i0(i0), .tick(tick), .wrap(wrap), .blank(blank)
    );

    scan_index_gen #(.DIV_W(8), .DIV(1), .BLANK_CYC(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .dir(1'b0), .load(1'b0), .load_val(2'd0),
        .i1(d1_i1), .i0(d1_i0), .tick(d1_tick), .wrap(d1_wrap), .blank(d1_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        if (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance n rising edges and settle 1ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        en1      = 1'b0;
        dir      = 1'b0;
        load     = 1'b0;
        load_val = 2'd0;

        step(2);
        check_val("rst_idx",   {30'd0, i1, i0}, 32'd0);
        check_val("rst_blank", {31'd0, blank}, 32'd1);
        check_val("rst_tick",  {31'd0, tick}, 32'd0);
        check_val("rst_wrap",  {31'd0, wrap}, 32'd0);
        rst_n = 1'b1;
        step(1);
        check_val("idle_blank", {31'd0, blank}, 32'd1);
        en  = 1'b1;
        en1 = 1'b1;
        step(1);
        check_val("run_blank", {31'd0, blank}, 32'd0);
        check_val("run_idx0",  {30'd0, i1, i0}, 32'd0);
        exp_idx = 0;

`ifdef SCAN_BLANK_EN
        // T6: step, two gated cycles, then ungated; 6 cycles per step.
        for (int k = 1; k <= 4; k++) begin
            step(3);
            check_val("bl_pre_tick",  {31'd0, tick}, 32'd0);
            check_val("bl_pre_idx",   {30'd0, i1, i0}, 32'(exp_idx));
            check_val("bl_pre_blank", {31'd0, blank}, 32'd0);
            step(1);
            exp_idx = (exp_idx + 1) % 4;
            check_val("bl_step_idx",   {30'd0, i1, i0}, 32'(exp_idx));
            check_val("bl_step_tick",  {31'd0, tick}, 32'd1);
            check_val("bl_step_wrap",  {31'd0, wrap}, (exp_idx == 0) ? 32'd1 : 32'd0);
            check_val("bl_step_blank", {31'd0, blank}, 32'd1);
            step(1);
            check_val("bl_hold_blank", {31'd0, blank}, 32'd1);
            check_val("bl_hold_tick",  {31'd0, tick}, 32'd0);
            check_val("bl_hold_idx",   {30'd0, i1, i0}, 32'(exp_idx));
            step(1);
            check_val("bl_end_blank", {31'd0, blank}, 32'd0);
            check_val("bl_end_idx",   {30'd0, i1, i0}, 32'(exp_idx));
        end
`else
        // T2: up scan every 4 cycles; DIV=1 instance steps every cycle.
        for (int k = 1; k <= 4; k++) begin
            step(3);
            check_val("up_pre_tick", {31'd0, tick}, 32'd0);
            check_val("up_pre_idx",  {30'd0, i1, i0}, 32'(exp_idx));
            check_val("d1_idx3",     {30'd0, d1_i1, d1_i0}, 32'd3);
            check_val("d1_tick_a",   {31'd0, d1_tick}, 32'd1);
            check_val("d1_nowrap",   {31'd0, d1_wrap}, 32'd0);
            step(1);
            exp_idx = (exp_idx + 1) % 4;
            check_val("up_idx",  {30'd0, i1, i0}, 32'(exp_idx));
            check_val("up_tick", {31'd0, tick}, 32'd1);
            check_val("up_wrap", {31'd0, wrap}, (exp_idx == 0) ? 32'd1 : 32'd0);
            check_val("d1_idx0",   {30'd0, d1_i1, d1_i0}, 32'd0);
            check_val("d1_tick_b", {31'd0, d1_tick}, 32'd1);
            check_val("d1_wrap",   {31'd0, d1_wrap}, 32'd1);
        end

        // T3: down from 0 wraps to 3; flip back up mid-period wraps to 0.
        dir = 1'b1;
        step(4);
        check_val("dn_idx",  {30'd0, i1, i0}, 32'd3);
        check_val("dn_tick", {31'd0, tick}, 32'd1);
        check_val("dn_wrap", {31'd0, wrap}, 32'd1);
        step(2);
        dir = 1'b0;
        step(2);
        check_val("flip_idx",  {30'd0, i1, i0}, 32'd0);
        check_val("flip_wrap", {31'd0, wrap}, 32'd1);

        // T4: load on the step edge wins and restarts the prescaler.
        step(3);
        load     = 1'b1;
        load_val = 2'd2;
        step(1);
        load = 1'b0;
        check_val("ld_idx",  {30'd0, i1, i0}, 32'd2);
        check_val("ld_tick", {31'd0, tick}, 32'd0);
        check_val("ld_wrap", {31'd0, wrap}, 32'd0);
        step(3);
        check_val("ld_pre_tick", {31'd0, tick}, 32'd0);
        check_val("ld_pre_idx",  {30'd0, i1, i0}, 32'd2);
        step(1);
        check_val("ld_next_idx",  {30'd0, i1, i0}, 32'd3);
        check_val("ld_next_tick", {31'd0, tick}, 32'd1);

        // T5: stop on a step edge at idx=1, then restart.
        load     = 1'b1;
        load_val = 2'd1;
        step(1);
        load = 1'b0;
        check_val("ld1_idx", {30'd0, i1, i0}, 32'd1);
        step(3);
        en = 1'b0;
        step(1);
        check_val("stop_idx",   {30'd0, i1, i0}, 32'd1);
        check_val("stop_tick",  {31'd0, tick}, 32'd0);
        check_val("stop_blank", {31'd0, blank}, 32'd1);
        step(2);
        check_val("stopped_idx",  {30'd0, i1, i0}, 32'd1);
        check_val("stopped_tick", {31'd0, tick}, 32'd0);
        en = 1'b1;
        step(1);
        check_val("restart_blank", {31'd0, blank}, 32'd0);
        check_val("restart_idx",   {30'd0, i1, i0}, 32'd1);
        step(3);
        check_val("restart_pre_idx",  {30'd0, i1, i0}, 32'd1);
        check_val("restart_pre_tick", {31'd0, tick}, 32'd0);
        step(1);
        check_val("restart_step_idx",  {30'd0, i1, i0}, 32'd2);
        check_val("restart_step_tick", {31'd0, tick}, 32'd1);
`endif

        // T1: asynchronous reset while running at idx=2.
        load     = 1'b1;
        load_val = 2'd2;
        step(1);
        load = 1'b0;
        check_val("pre_rst_idx", {30'd0, i1, i0}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_idx",   {30'd0, i1, i0}, 32'd0);
        check_val("arst_blank", {31'd0, blank}, 32'd1);
        check_val("arst_tick",  {31'd0, tick}, 32'd0);
        check_val("arst_wrap",  {31'd0, wrap}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("post_rst_blank", {31'd0, blank}, 32'd1);
        step(1);
        check_val("rerun_blank", {31'd0, blank}, 32'd0);
        check_val("rerun_idx",   {30'd0, i1, i0}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
